// File: rtl/cpu_core_pkg.sv
// Shared opcode encodings, ALU source selectors and load-enable bit positions
// for the parametrised accumulator CPU core.
package cpu_core_pkg;

  localparam int unsigned OPCODE_W = 4;

  // Every 4-bit pattern is named, so casting a raw opcode field is always legal.
  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD_A   = 4'b0000,
    OP_MOV_A_B = 4'b0001,
    OP_IN_A    = 4'b0010,
    OP_MOV_A_I = 4'b0011,
    OP_MOV_B_A = 4'b0100,
    OP_ADD_B   = 4'b0101,
    OP_IN_B    = 4'b0110,
    OP_MOV_B_I = 4'b0111,
    OP_NOP_8   = 4'b1000,
    OP_OUT_B   = 4'b1001,
    OP_NOP_A   = 4'b1010,
    OP_OUT_I   = 4'b1011,
    OP_HALT    = 4'b1100,
    OP_NOP_D   = 4'b1101,
    OP_JNC     = 4'b1110,
    OP_JMP     = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2,
    SRC_IN   = 2'd3
  } src_sel_t;

  localparam int unsigned LD_A   = 0;
  localparam int unsigned LD_B   = 1;
  localparam int unsigned LD_OUT = 2;
  localparam int unsigned LD_PC  = 3;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder: opcode and current carry flag to
// ALU source select, register load enables {pc,out,b,a}, halt and carry write.
module cpu_decoder
  import cpu_core_pkg::*;
(
  input  opcode_t    opcode,
  input  logic       c,
  output src_sel_t   src_sel,
  output logic [3:0] ld,
  output logic       halt,
  output logic       c_we
);

  always_comb begin
    src_sel = SRC_ZERO;
    ld      = '0;
    halt    = 1'b0;
    c_we    = 1'b1;
    case (opcode)
      OP_ADD_A:   begin src_sel = SRC_A;  ld[LD_A]   = 1'b1; end
      OP_MOV_A_B: begin src_sel = SRC_B;  ld[LD_A]   = 1'b1; end
      OP_IN_A:    begin src_sel = SRC_IN; ld[LD_A]   = 1'b1; end
      OP_MOV_A_I: begin                   ld[LD_A]   = 1'b1; end
      OP_MOV_B_A: begin src_sel = SRC_A;  ld[LD_B]   = 1'b1; end
      OP_ADD_B:   begin src_sel = SRC_B;  ld[LD_B]   = 1'b1; end
      OP_IN_B:    begin src_sel = SRC_IN; ld[LD_B]   = 1'b1; end
      OP_MOV_B_I: begin                   ld[LD_B]   = 1'b1; end
      OP_OUT_B:   begin src_sel = SRC_B;  ld[LD_OUT] = 1'b1; end
      OP_OUT_I:   begin                   ld[LD_OUT] = 1'b1; end
      OP_JMP:     begin                   ld[LD_PC]  = 1'b1; end
      // JNC tests the carry left by the previous instruction, then clears it.
      OP_JNC:     begin                   ld[LD_PC]  = ~c;   end
      OP_HALT:    begin halt = 1'b1; c_we = 1'b0; end
      default:    begin c_we = 1'b0; end
    endcase
  end

endmodule

// File: rtl/cpu_core_param.sv
// Parametrised single-cycle accumulator CPU core with external program memory,
// step enable, sticky HALT and a one-cycle output strobe.
module cpu_core_param
  import cpu_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET,
  input  logic                         en,
  output logic [ADDR_WIDTH-1:0]        pc_addr,
  input  logic [OPCODE_W+DATA_WIDTH-1:0] instr_in,
  input  logic [DATA_WIDTH-1:0]        in_port,
  output logic [DATA_WIDTH-1:0]        out_port,
  output logic                         out_valid,
  output logic                         carry,
  output logic                         halted
);

  logic [DATA_WIDTH-1:0] a_q, b_q, out_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  c_q, halted_q, out_valid_q;

  opcode_t               opcode;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] src;
  logic [DATA_WIDTH:0]   sum;
  src_sel_t              src_sel;
  logic [3:0]            ld;
  logic                  halt, c_we, exec;

  assign opcode = opcode_t'(instr_in[OPCODE_W+DATA_WIDTH-1 -: OPCODE_W]);
  assign imm    = instr_in[DATA_WIDTH-1:0];
  assign exec   = en & ~halted_q;

  cpu_decoder u_dec (
    .opcode  (opcode),
    .c       (c_q),
    .src_sel (src_sel),
    .ld      (ld),
    .halt    (halt),
    .c_we    (c_we)
  );

  always_comb begin
    src = '0;
    case (src_sel)
      SRC_A:   src = a_q;
      SRC_B:   src = b_q;
      SRC_IN:  src = in_port;
      default: src = '0;
    endcase
  end

  assign sum = {1'b0, src} + {1'b0, imm};

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      pc_q        <= '0;
      c_q         <= 1'b0;
      halted_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (exec) begin
        if (ld[LD_A])   a_q   <= sum[DATA_WIDTH-1:0];
        if (ld[LD_B])   b_q   <= sum[DATA_WIDTH-1:0];
        if (ld[LD_OUT]) out_q <= sum[DATA_WIDTH-1:0];
        if (c_we)       c_q   <= sum[DATA_WIDTH];
        out_valid_q <= ld[LD_OUT];
        if (halt)
          halted_q <= 1'b1;
        else if (ld[LD_PC])
          pc_q <= imm[ADDR_WIDTH-1:0];
        else
          pc_q <= pc_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign pc_addr   = pc_q;
  assign out_port  = out_q;
  assign out_valid = out_valid_q;
  assign carry     = c_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_core_param.sv
// Directed bench for cpu_core_param: 4/4 core driven from a vector table and a
// small ROM, plus an 8/6 instance for wide-carry and PC-wrap corners.
module tb_cpu_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit data / 4-bit address instance
  logic        rst4, en4, use_rom;
  logic [3:0]  pc4, in4, out4;
  logic [7:0]  instr4, drv_instr4;
  logic        ov4, c4, h4;
  logic [7:0]  rom4 [16];

  assign instr4 = use_rom ? rom4[pc4] : drv_instr4;

  cpu_core_param #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) dut4 (
    .CLOCK_50 (clk),
    .RESET    (rst4),
    .en       (en4),
    .pc_addr  (pc4),
    .instr_in (instr4),
    .in_port  (in4),
    .out_port (out4),
    .out_valid(ov4),
    .carry    (c4),
    .halted   (h4)
  );

  // 8-bit data / 6-bit address instance
  logic        rst8, en8;
  logic [5:0]  pc8;
  logic [11:0] instr8;
  logic [7:0]  in8, out8;
  logic        ov8, c8, h8;

  cpu_core_param #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut8 (
    .CLOCK_50 (clk),
    .RESET    (rst8),
    .en       (en8),
    .pc_addr  (pc8),
    .instr_in (instr8),
    .in_port  (in8),
    .out_port (out8),
    .out_valid(ov8),
    .carry    (c8),
    .halted   (h8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] imm;
    logic       en;
    logic [3:0] din;
    logic [3:0] pc;
    logic [3:0] out;
    logic       c;
    logic       ov;
    logic       h;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, input logic [3:0] imm, input logic en,
                              input logic [3:0] din, input logic [3:0] pc, input logic [3:0] out,
                              input logic c, input logic ov, input logic h);
    vec_t v;
    v.op = op; v.imm = imm; v.en = en; v.din = din;
    v.pc = pc; v.out = out; v.c = c; v.ov = ov; v.h = h;
    return v;
  endfunction

  task automatic reset4();
    rst4 = 1'b1;
    en4  = 1'b1;
    repeat (2) @(negedge clk);
    rst4 = 1'b0;
  endtask

  task automatic step8(input logic [11:0] ins);
    instr8 = ins;
    @(negedge clk);
  endtask

  vec_t tbl [31];
  int   pulses, first_ov;
  logic c_at31;

  initial begin
    rst4 = 1'b1; en4 = 1'b0; use_rom = 1'b1; in4 = '0; drv_instr4 = 8'h80;
    rst8 = 1'b1; en8 = 1'b0; in8 = '0; instr8 = 12'h800;
    for (int unsigned i = 0; i < 16; i++) rom4[i] = 8'h80;

    // ---- Reset mid-program, HALT at address 4 ----
    rom4[0] = 8'h35; rom4[1] = 8'h77; rom4[2] = 8'h90; rom4[3] = 8'h0F; rom4[4] = 8'hC0;
    reset4();
    repeat (5) @(negedge clk);
    check("halt.pc", 32'(pc4), 32'd4);
    check("halt.out", 32'(out4), 32'd7);
    check("halt.carry", 32'(c4), 32'd1);
    check("halt.halted", 32'(h4), 32'd1);
    check("halt.ov", 32'(ov4), 32'd0);
    repeat (3) @(negedge clk);
    check("halt.pc_hold", 32'(pc4), 32'd4);
    check("halt.c_hold", 32'(c4), 32'd1);
    rst4 = 1'b1;
    @(negedge clk);
    check("rst.pc_first", 32'(pc4), 32'd0);
    check("rst.halted_first", 32'(h4), 32'd0);
    use_rom = 1'b0;
    drv_instr4 = 8'h90;
    @(negedge clk);
    rst4 = 1'b0;
    check("rst.pc", 32'(pc4), 32'd0);
    check("rst.out", 32'(out4), 32'd0);
    check("rst.carry", 32'(c4), 32'd0);
    check("rst.halted", 32'(h4), 32'd0);
    check("rst.ov", 32'(ov4), 32'd0);
    @(negedge clk);
    check("rst.b_zero", 32'(out4), 32'd0);
    check("rst.b_ov", 32'(ov4), 32'd1);
    drv_instr4 = 8'h40;
    @(negedge clk);
    drv_instr4 = 8'h90;
    @(negedge clk);
    check("rst.a_zero", 32'(out4), 32'd0);

    // ---- Vector table: op, imm, en, in_port -> pc, out, carry, out_valid, halted ----
    tbl[0]  = mk(4'h3, 4'h9, 1, 4'h0, 4'd1,  4'h0, 0, 0, 0);
    tbl[1]  = mk(4'h0, 4'h8, 1, 4'h0, 4'd2,  4'h0, 1, 0, 0);
    tbl[2]  = mk(4'h7, 4'h3, 1, 4'h0, 4'd3,  4'h0, 0, 0, 0);
    tbl[3]  = mk(4'h9, 4'h0, 1, 4'h0, 4'd4,  4'h3, 0, 1, 0);
    tbl[4]  = mk(4'h4, 4'h0, 1, 4'h0, 4'd5,  4'h3, 0, 0, 0);
    tbl[5]  = mk(4'h9, 4'h0, 1, 4'h0, 4'd6,  4'h1, 0, 1, 0);
    tbl[6]  = mk(4'h9, 4'h0, 1, 4'h0, 4'd7,  4'h1, 0, 1, 0);
    tbl[7]  = mk(4'h6, 4'h0, 1, 4'hA, 4'd8,  4'h1, 0, 0, 0);
    tbl[8]  = mk(4'h9, 4'h0, 1, 4'h0, 4'd9,  4'hA, 0, 1, 0);
    tbl[9]  = mk(4'h8, 4'h5, 1, 4'h0, 4'd10, 4'hA, 0, 0, 0);
    tbl[10] = mk(4'h3, 4'hF, 1, 4'h0, 4'd11, 4'hA, 0, 0, 0);
    tbl[11] = mk(4'h0, 4'h1, 1, 4'h0, 4'd12, 4'hA, 1, 0, 0);
    tbl[12] = mk(4'hA, 4'h3, 1, 4'h0, 4'd13, 4'hA, 1, 0, 0);
    tbl[13] = mk(4'hD, 4'h0, 1, 4'h0, 4'd14, 4'hA, 1, 0, 0);
    tbl[14] = mk(4'h2, 4'h0, 1, 4'h5, 4'd15, 4'hA, 0, 0, 0);
    tbl[15] = mk(4'hB, 4'h6, 1, 4'h0, 4'd0,  4'h6, 0, 1, 0);
    tbl[16] = mk(4'hB, 4'h9, 0, 4'h0, 4'd0,  4'h6, 0, 0, 0);
    tbl[17] = mk(4'h5, 4'hF, 1, 4'h0, 4'd1,  4'h6, 1, 0, 0);
    tbl[18] = mk(4'hE, 4'h5, 1, 4'h0, 4'd2,  4'h6, 0, 0, 0);
    tbl[19] = mk(4'hE, 4'h7, 1, 4'h0, 4'd7,  4'h6, 0, 0, 0);
    tbl[20] = mk(4'hF, 4'h3, 1, 4'h0, 4'd3,  4'h6, 0, 0, 0);
    tbl[21] = mk(4'h3, 4'h8, 1, 4'h0, 4'd4,  4'h6, 0, 0, 0);
    tbl[22] = mk(4'h0, 4'h8, 1, 4'h0, 4'd5,  4'h6, 1, 0, 0);
    tbl[23] = mk(4'h0, 4'hF, 0, 4'h0, 4'd5,  4'h6, 1, 0, 0);
    tbl[24] = mk(4'h0, 4'hF, 0, 4'h0, 4'd5,  4'h6, 1, 0, 0);
    tbl[25] = mk(4'h0, 4'hF, 0, 4'h0, 4'd5,  4'h6, 1, 0, 0);
    tbl[26] = mk(4'h4, 4'h3, 1, 4'h0, 4'd6,  4'h6, 0, 0, 0);
    tbl[27] = mk(4'h9, 4'h0, 1, 4'h0, 4'd7,  4'h3, 0, 1, 0);
    tbl[28] = mk(4'hC, 4'h0, 1, 4'h0, 4'd7,  4'h3, 0, 0, 1);
    tbl[29] = mk(4'hB, 4'h5, 1, 4'h0, 4'd7,  4'h3, 0, 0, 1);
    tbl[30] = mk(4'hF, 4'h0, 1, 4'h0, 4'd7,  4'h3, 0, 0, 1);

    use_rom = 1'b0;
    drv_instr4 = 8'h80;
    reset4();
    for (int i = 0; i < 31; i++) begin
      drv_instr4 = {tbl[i].op, tbl[i].imm};
      en4 = tbl[i].en;
      in4 = tbl[i].din;
      @(negedge clk);
      check($sformatf("v%0d.pc", i), 32'(pc4), 32'(tbl[i].pc));
      check($sformatf("v%0d.out", i), 32'(out4), 32'(tbl[i].out));
      check($sformatf("v%0d.carry", i), 32'(c4), 32'(tbl[i].c));
      check($sformatf("v%0d.ov", i), 32'(ov4), 32'(tbl[i].ov));
      check($sformatf("v%0d.halted", i), 32'(h4), 32'(tbl[i].h));
    end

    // ---- JNC counting loop from ROM ----
    for (int unsigned i = 0; i < 16; i++) rom4[i] = 8'h80;
    rom4[0] = 8'h01; rom4[1] = 8'hE0; rom4[2] = 8'hB7; rom4[3] = 8'hC0;
    use_rom = 1'b1;
    reset4();
    en4 = 1'b1;
    pulses = 0; first_ov = 0; c_at31 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ov4 === 1'b1) begin
        pulses++;
        if (first_ov == 0) first_ov = k;
      end
      if (k == 31) c_at31 = c4;
    end
    check("loop.carry_at_wrap", 32'(c_at31), 32'd1);
    check("loop.first_ov_cycle", 32'(first_ov), 32'd33);
    check("loop.ov_pulses", 32'(pulses), 32'd1);
    check("loop.out", 32'(out4), 32'd7);
    check("loop.pc", 32'(pc4), 32'd3);
    check("loop.halted", 32'(h4), 32'd1);
    check("loop.carry_end", 32'(c4), 32'd0);

    // ---- 8-bit data, 6-bit address ----
    rst8 = 1'b1; en8 = 1'b1;
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    check("w.rst_pc", 32'(pc8), 32'd0);
    step8(12'h3F0);
    check("w.mov_pc", 32'(pc8), 32'd1);
    check("w.mov_c", 32'(c8), 32'd0);
    step8(12'h020);
    check("w.add_c", 32'(c8), 32'd1);
    step8(12'h400);
    check("w.movba_c", 32'(c8), 32'd0);
    step8(12'h900);
    check("w.out", 32'(out8), 32'h10);
    check("w.ov", 32'(ov8), 32'd1);
    check("w.out_pc", 32'(pc8), 32'd4);
    step8(12'hF3F);
    check("w.jmp_pc", 32'(pc8), 32'h3F);
    check("w.jmp_ov", 32'(ov8), 32'd0);
    step8(12'h800);
    check("w.wrap_pc", 32'(pc8), 32'd0);
    step8(12'hFFF);
    check("w.jmp_trunc_pc", 32'(pc8), 32'h3F);
    step8(12'h5F0);
    check("w.addb_c", 32'(c8), 32'd1);
    step8(12'h900);
    check("w.out_zero", 32'(out8), 32'd0);
    check("w.halted", 32'(h8), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
